// File: rtl/matmul_sequencer.sv
// Sequenced 3x3 matrix multiplier: streams in A then B, computes C = A x B
// with one shared multiply-accumulate unit, and emits C row-major over valid/ready.
module matmul_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [3:0]        res_idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NumElem = N * N;
    localparam int unsigned Depth   = 2 * NumElem;

    typedef enum logic [1:0] {StLoad, StMac, StOut} state_e;

    state_e            state_q, state_d;
    logic [4:0]        load_cnt_q, load_cnt_d;
    logic [3:0]        elem_q, elem_d;
    logic [1:0]        k_q, k_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] mem_d [Depth];

    logic [4:0]        row_base, col, k_stride, a_addr, b_addr;
    logic [DATA_W-1:0] prod;

    // Operand addressing: A[r*3+k] and B[k*3+c], with B stored after A.
    always_comb begin
        row_base = 5'd0;
        col      = 5'(elem_q);
        if (elem_q >= 4'd6) begin
            row_base = 5'd6;
            col      = 5'(elem_q - 4'd6);
        end else if (elem_q >= 4'd3) begin
            row_base = 5'd3;
            col      = 5'(elem_q - 4'd3);
        end
        k_stride = {3'b000, k_q} + {2'b00, k_q, 1'b0};
        a_addr   = row_base + {3'b000, k_q};
        b_addr   = 5'(NumElem) + k_stride + col;
    end

    // Product and sum both wrap at DATA_W bits.
    assign prod = mem_q[a_addr] * mem_q[b_addr];

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        elem_d     = elem_q;
        k_d        = k_q;
        acc_d      = acc_q;
        done_d     = 1'b0;
        mem_d      = mem_q;

        unique case (state_q)
            StLoad: begin
                if (load_valid) begin
                    mem_d[load_cnt_q] = load_data;
                    if (load_cnt_q == 5'(Depth - 1)) begin
                        load_cnt_d = 5'd0;
                        elem_d     = 4'd0;
                        k_d        = 2'd0;
                        state_d    = StMac;
                    end else begin
                        load_cnt_d = load_cnt_q + 5'd1;
                    end
                end
            end
            StMac: begin
                acc_d = (k_q == 2'd0) ? prod : acc_q + prod;
                if (k_q == 2'd2) begin
                    k_d     = 2'd0;
                    state_d = StOut;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            StOut: begin
                if (res_ready) begin
                    if (elem_q == 4'(NumElem - 1)) begin
                        state_d = StLoad;
                        done_d  = 1'b1;
                    end else begin
                        elem_d  = elem_q + 4'd1;
                        state_d = StMac;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            load_cnt_q <= 5'd0;
            elem_q     <= 4'd0;
            k_q        <= 2'd0;
            acc_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            elem_q     <= elem_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            done_q     <= done_d;
        end
    end

    // Matrix storage is fully rewritten by every job, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign load_ready = (state_q == StLoad);
    assign res_valid  = (state_q == StOut);
    assign res_data   = res_valid ? acc_q : '0;
    assign res_idx    = res_valid ? elem_q : 4'd0;
    assign busy       = (state_q != StLoad);
    assign done       = done_q;

    a_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done && res_valid));
    a_res_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (res_valid && !res_ready) |=> (res_valid && $stable(res_data) && $stable(res_idx)));

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: table of jobs and runs, scoreboard of
// expected results, plus hand-written reset-abort sequence.
module tb_matmul_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = 8'd0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic [3:0] res_idx;
    logic       busy;
    logic       done;

    matmul_sequencer #(.DATA_W(8), .N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a [9];
        logic [7:0] b [9];
        logic [7:0] c [9];
    } job_t;

    typedef struct {
        int job;
        bit gaps;
        int stall_idx;
        int stall_len;
    } run_t;

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
    } res_t;

    job_t jobs [4];
    run_t runs [6];
    res_t sb [$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Starts driving at the current negedge; returns at the negedge after the last load.
    task automatic load_job(input int j, input bit gaps, input bit push, output int t_last);
        int   n = 0;
        int   c = 0;
        res_t r;
        t_last = 0;
        if (push) begin
            for (int i = 0; i < 9; i++) begin
                r.idx  = 4'(i);
                r.data = jobs[j].c[i];
                sb.push_back(r);
            end
        end
        while (n < 18 && c < 100) begin
            if (gaps && (c % 3 == 2)) begin
                load_valid = 1'b0;
            end else begin
                load_valid = 1'b1;
                load_data  = (n < 9) ? jobs[j].a[n] : jobs[j].b[n-9];
                check("load_ready", load_ready, 1);
                if (n == 17) t_last = cyc;
                n++;
            end
            c++;
            @(negedge clk);
        end
        load_valid = 1'b0;
        check("mac_busy", busy, 1);
        check("mac_load_ready", load_ready, 0);
        check("mac_res_valid", res_valid, 0);
    endtask

    task automatic receive(input int t_last, input int stall_idx, input int stall_len);
        int   budget = 0;
        int   stalled = 0;
        bit   first = 1'b1;
        res_t exp;
        while (sb.size() > 0 && budget < 300) begin
            check("busy", busy, 1);
            check("done_quiet", done, 0);
            if (res_valid) begin
                exp = sb[0];
                if (first) begin
                    check("first_latency", cyc - t_last, 4);
                    first = 1'b0;
                end
                check("res_idx", res_idx, exp.idx);
                check("res_data", res_data, exp.data);
                if (exp.idx == stall_idx && stalled < stall_len) begin
                    res_ready = 1'b0;
                    stalled++;
                end else begin
                    res_ready = 1'b1;
                    void'(sb.pop_front());
                end
            end else begin
                res_ready = 1'b1;
            end
            @(negedge clk);
            budget++;
        end
        res_ready = 1'b1;
        if (sb.size() > 0) begin
            check("result_timeout", sb.size(), 0);
            sb.delete();
        end
        check("done_pulse", done, 1);
        check("done_load_ready", load_ready, 1);
        check("done_res_valid", res_valid, 0);
        check("job_latency", cyc - t_last, 37 + stall_len);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_ready"}, load_ready, 1);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_idx"}, res_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int budget;
        bit seen;

        for (int i = 0; i < 9; i++) begin
            jobs[0].a[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
            jobs[0].b[i] = 8'(i + 1);
            jobs[1].a[i] = 8'(i + 1);
            jobs[1].b[i] = 8'(9 - i);
            jobs[2].a[i] = 8'd10;
            jobs[2].b[i] = 8'd10;
            jobs[2].c[i] = 8'd44;
            jobs[3].a[i] = 8'd16;
            jobs[3].b[i] = 8'd16;
            jobs[3].c[i] = 8'd0;
        end
        jobs[0].c = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        jobs[1].c = '{8'd30, 8'd24, 8'd18, 8'd84, 8'd69, 8'd54, 8'd138, 8'd114, 8'd90};

        runs[0] = '{job: 0, gaps: 1'b0, stall_idx: -1, stall_len: 0};
        runs[1] = '{job: 1, gaps: 1'b0, stall_idx: -1, stall_len: 0};
        runs[2] = '{job: 2, gaps: 1'b1, stall_idx: -1, stall_len: 0};
        runs[3] = '{job: 3, gaps: 1'b1, stall_idx: -1, stall_len: 0};
        runs[4] = '{job: 1, gaps: 1'b0, stall_idx: 4, stall_len: 5};
        runs[5] = '{job: 0, gaps: 1'b1, stall_idx: 8, stall_len: 2};

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // Each run begins loading in the same cycle the previous done is high.
        for (int r = 0; r < 6; r++) begin
            load_job(runs[r].job, runs[r].gaps, 1'b1, t);
            receive(t, runs[r].stall_idx, runs[r].stall_len);
        end

        // Abort a job at elem 3, k 1, then rerun identity from scratch.
        load_job(0, 1'b0, 1'b0, t);
        seen = 1'b0;
        budget = 0;
        while (!seen && budget < 100) begin
            res_ready = 1'b1;
            if (res_valid && res_idx == 4'd2) seen = 1'b1;
            @(negedge clk);
            budget++;
        end
        check("abort_reach_idx2", seen, 1);
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        check_reset_outputs("abort_hold");
        rst_n = 1'b1;
        @(negedge clk);
        load_job(0, 1'b0, 1'b1, t);
        receive(t, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
